// File: rtl/nic_rx_pkg.sv
// Shared types and defaults for the NIC receive path.
package nic_rx_pkg;

  localparam int DEF_DATA_W          = 64;
  localparam int DEF_KEEP_W          = DEF_DATA_W / 8;
  localparam int DEF_MAX_FRAME_WORDS = 190;   // 1518-byte frame in 64-bit words
  localparam int DEF_FREE_W          = 16;
  localparam int DEF_CNT_W           = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DROP  = 2'd2,
    TRUNC = 2'd3
  } state_t;

endpackage

// File: rtl/rx_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module rx_sat_counter
  import nic_rx_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame admission controller: forward whole frames when the RX FIFO can hold a maximum-size
// frame, drop otherwise, truncate overlong frames. Define RX_FRAME_CTRL_STATS_EN for counters.
module rx_frame_ctrl
  import nic_rx_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int KEEP_W          = DATA_W / 8,
  parameter int MAX_FRAME_WORDS = DEF_MAX_FRAME_WORDS,
  parameter int FREE_W          = DEF_FREE_W,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic [KEEP_W-1:0] in_tkeep,
  input  logic              in_tvalid,
  input  logic              in_tlast,
  input  logic              in_tuser,
  input  logic [FREE_W-1:0] fifo_free_words,
  output logic [DATA_W-1:0] out_tdata,
  output logic [KEEP_W-1:0] out_tkeep,
  output logic              out_tvalid,
  output logic              out_tlast,
  output logic              out_tuser,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_ok_cnt,
  output logic [CNT_W-1:0]  frame_drop_cnt,
  output logic [CNT_W-1:0]  frame_err_cnt
);

  localparam int WC_W = $clog2(MAX_FRAME_WORDS + 1);
  // word_cnt holds the count of words already forwarded, so this value means "next word is the last allowed".
  localparam logic [WC_W-1:0]   TRUNC_AT  = WC_W'(MAX_FRAME_WORDS - 1);
  localparam logic [FREE_W-1:0] ADMIT_MIN = FREE_W'(MAX_FRAME_WORDS);

  state_t          state;
  logic [WC_W-1:0] word_cnt;
  logic            admit;

  assign admit = enable && (fifo_free_words >= ADMIT_MIN);
  assign busy  = (state != IDLE);

  // NOTE: reset here is synchronous and every state register uses non-blocking assignment,
  // so all flops update together on the edge and no read-after-write ordering leaks in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word_cnt   <= '0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tuser  <= 1'b0;
    end else begin
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tuser  <= 1'b0;
      if (in_tvalid) begin
        case (state)
          IDLE: begin
            if (admit) begin
              out_tdata  <= in_tdata;
              out_tkeep  <= in_tkeep;
              out_tvalid <= 1'b1;
              word_cnt   <= WC_W'(1);
              if (in_tlast) begin
                out_tlast <= 1'b1;
                out_tuser <= in_tuser;
              end else begin
                state <= PASS;
              end
            end else if (!in_tlast) begin
              state <= DROP;
            end
          end
          PASS: begin
            out_tdata  <= in_tdata;
            out_tkeep  <= in_tkeep;
            out_tvalid <= 1'b1;
            word_cnt   <= word_cnt + 1'b1;
            if (in_tlast) begin
              out_tlast <= 1'b1;
              out_tuser <= in_tuser;
              state     <= IDLE;
            end else if (word_cnt == TRUNC_AT) begin
              out_tlast <= 1'b1;
              out_tuser <= 1'b1;
              state     <= TRUNC;
            end
          end
          DROP, TRUNC: begin
            if (in_tlast) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef RX_FRAME_CTRL_STATS_EN
  logic ok_inc, drop_inc, err_inc;

  // Decoded from the deciding word itself so counters move on the same edge that samples it.
  always_comb begin
    ok_inc   = 1'b0;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    if (in_tvalid) begin
      case (state)
        IDLE: begin
          if (admit && in_tlast) begin
            err_inc = in_tuser;
            ok_inc  = !in_tuser;
          end else if (!admit && in_tlast) begin
            drop_inc = 1'b1;
          end
        end
        PASS: begin
          if (in_tlast) begin
            err_inc = in_tuser;
            ok_inc  = !in_tuser;
          end else if (word_cnt == TRUNC_AT) begin
            err_inc = 1'b1;
          end
        end
        DROP:    drop_inc = in_tlast;
        default: ;
      endcase
    end
  end

  rx_sat_counter #(.W(CNT_W)) u_ok_cnt (
    .clk(clk), .reset(reset), .inc(ok_inc), .count(frame_ok_cnt)
  );
  rx_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk(clk), .reset(reset), .inc(drop_inc), .count(frame_drop_cnt)
  );
  rx_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .reset(reset), .inc(err_inc), .count(frame_err_cnt)
  );
`else
  assign frame_ok_cnt   = '0;
  assign frame_drop_cnt = '0;
  assign frame_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl with a short maximum frame and narrow counters.
module tb_rx_frame_ctrl;

  localparam int MAXW = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [63:0] in_tdata;
  logic [7:0]  in_tkeep;
  logic        in_tvalid, in_tlast, in_tuser;
  logic [15:0] fifo_free_words;
  logic [63:0] out_tdata;
  logic [7:0]  out_tkeep;
  logic        out_tvalid, out_tlast, out_tuser, busy;
  logic [CW-1:0] frame_ok_cnt, frame_drop_cnt, frame_err_cnt;

  always #5 clk = ~clk;

  rx_frame_ctrl #(
    .DATA_W(64), .KEEP_W(8), .MAX_FRAME_WORDS(MAXW), .FREE_W(16), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tvalid(in_tvalid),
    .in_tlast(in_tlast), .in_tuser(in_tuser), .fifo_free_words(fifo_free_words),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tvalid(out_tvalid),
    .out_tlast(out_tlast), .out_tuser(out_tuser), .busy(busy),
    .frame_ok_cnt(frame_ok_cnt), .frame_drop_cnt(frame_drop_cnt),
    .frame_err_cnt(frame_err_cnt)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
    int          c;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   e_ok = 0, e_drop = 0, e_err = 0;
  logic busy_seen;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [63:0] stat(input int v);
`ifdef RX_FRAME_CTRL_STATS_EN
    return 64'(v);
`else
    return (v == v) ? 64'd0 : 64'd1;
`endif
  endfunction

  task automatic check_cnt(input string tag);
    check({tag, "_ok_cnt"},   64'(frame_ok_cnt),   stat(e_ok));
    check({tag, "_drop_cnt"}, 64'(frame_drop_cnt), stat(e_drop));
    check({tag, "_err_cnt"},  64'(frame_err_cnt),  stat(e_err));
  endtask

  // Present one word; it is sampled on the following rising edge.
  task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic last,
                       input logic user, input bit fwd, input logic exp_last,
                       input logic exp_user);
    exp_t e;
    @(negedge clk);
    busy_seen = busy;
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tkeep  = k;
    in_tlast  = last;
    in_tuser  = user;
    if (fwd) begin
      e.d = d; e.k = k; e.l = exp_last; e.u = exp_user; e.c = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_tvalid = 1'b0;
    in_tdata  = '0;
    in_tkeep  = '0;
    in_tlast  = 1'b0;
    in_tuser  = 1'b0;
  endtask

  // Monitor: every presented word must match the head of the scoreboard, one cycle after issue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset || cyc > 1) begin
      if (out_tvalid) begin
        if (q.size() == 0) begin
          check("unexpected_word", 64'(out_tdata), 64'hDEAD);
        end else begin
          e = q.pop_front();
          check("word_cycle", 64'(cyc), 64'(e.c));
          check("out_tdata", out_tdata, e.d);
          check("out_tkeep", 64'(out_tkeep), 64'(e.k));
          check("out_tlast", 64'(out_tlast), 64'(e.l));
          check("out_tuser", 64'(out_tuser), 64'(e.u));
        end
      end else begin
        check("idle_zero", 64'({out_tdata, out_tkeep, out_tlast, out_tuser} != '0), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; fifo_free_words = '0;
    in_tvalid = 1'b0; in_tdata = '0; in_tkeep = '0; in_tlast = 1'b0; in_tuser = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_tvalid", 64'(out_tvalid), 64'd0);
    check_cnt("reset");
    reset = 1'b0;

    // Admitted 3-word clean frame
    enable = 1'b1; fifo_free_words = 16'd200;
    drive(64'hA1, 8'hFF, 0, 0, 1, 0, 0);
    drive(64'hA2, 8'hFF, 0, 0, 1, 0, 0);
    check("admit_busy", 64'(busy_seen), 64'd1);
    drive(64'hA3, 8'h0F, 1, 0, 1, 1, 0);
    e_ok = sat(e_ok);
    idle();
    check("admit_busy_end", 64'(busy), 64'd0);
    check_cnt("admit3");

    // Space drop: free one below the admission threshold
    fifo_free_words = 16'(MAXW - 1);
    drive(64'hB1, 8'hFF, 0, 0, 0, 0, 0);
    drive(64'hB2, 8'hFF, 0, 0, 0, 0, 0);
    check("drop_busy", 64'(busy_seen), 64'd1);
    drive(64'hB3, 8'hFF, 0, 0, 0, 0, 0);
    drive(64'hB4, 8'hFF, 1, 0, 0, 0, 0);
    check("drop_busy_last", 64'(busy_seen), 64'd1);
    e_drop = sat(e_drop);
    idle();
    check("drop_busy_end", 64'(busy), 64'd0);
    check_cnt("space_drop");

    // Free exactly at threshold, single-word frame stays in IDLE
    fifo_free_words = 16'(MAXW);
    drive(64'hC1, 8'h03, 1, 0, 1, 1, 0);
    e_ok = sat(e_ok);
    idle();
    check("single_busy", 64'(busy), 64'd0);
    check_cnt("single");

    // Bad frame
    fifo_free_words = 16'd200;
    drive(64'hD1, 8'hFF, 0, 0, 1, 0, 0);
    drive(64'hD2, 8'h01, 1, 1, 1, 1, 1);
    e_err = sat(e_err);
    idle();
    check_cnt("bad_frame");

    // Truncation: 6 words, words 5-6 discarded
    drive(64'hE1, 8'hFF, 0, 0, 1, 0, 0);
    drive(64'hE2, 8'hFF, 0, 0, 1, 0, 0);
    drive(64'hE3, 8'hFF, 0, 0, 1, 0, 0);
    drive(64'hE4, 8'hFF, 0, 0, 1, 1, 1);
    e_err = sat(e_err);
    drive(64'hE5, 8'hFF, 0, 0, 0, 0, 0);
    drive(64'hE6, 8'hFF, 1, 0, 0, 0, 0);
    check("trunc_busy", 64'(busy_seen), 64'd1);
    idle();
    check("trunc_busy_end", 64'(busy), 64'd0);
    check_cnt("trunc");

    // enable falls mid-frame: frame still completes
    drive(64'hF1, 8'hFF, 0, 0, 1, 0, 0);
    enable = 1'b0;
    drive(64'hF2, 8'hFF, 0, 0, 1, 0, 0);
    drive(64'hF3, 8'h7F, 1, 0, 1, 1, 0);
    e_ok = sat(e_ok);
    idle();
    check_cnt("enable_mid");

    // enable low at first word: dropped despite free space
    drive(64'h11, 8'hFF, 1, 0, 0, 0, 0);
    e_drop = sat(e_drop);
    idle();
    check_cnt("disabled");
    enable = 1'b1;

    // Reset mid-PASS, then a normal 2-word frame
    drive(64'h21, 8'hFF, 0, 0, 1, 0, 0);
    drive(64'h22, 8'hFF, 0, 0, 1, 0, 0);
    @(negedge clk);
    reset = 1'b1; in_tvalid = 1'b0; in_tlast = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_tvalid", 64'(out_tvalid), 64'd0);
    check("rst_mid_tlast", 64'(out_tlast), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    e_ok = 0; e_drop = 0; e_err = 0;
    check_cnt("rst_mid");
    drive(64'h31, 8'hFF, 0, 0, 1, 0, 0);
    drive(64'h32, 8'h3F, 1, 0, 1, 1, 0);
    e_ok = sat(e_ok);
    idle();
    check_cnt("post_reset");

    // Saturation of the drop counter with back-to-back single-word drops
    fifo_free_words = '0;
    for (int i = 0; i < CMAX; i++) begin
      drive(64'(i), 8'hFF, 1, 0, 0, 0, 0);
      e_drop = sat(e_drop);
    end
    idle();
    check_cnt("drop_full");
    drive(64'h99, 8'hFF, 1, 0, 0, 0, 0);
    e_drop = sat(e_drop);
    idle();
    check("drop_saturated", 64'(frame_drop_cnt), stat(CMAX));
    check_cnt("drop_sat");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Frame admission controller between the byte-to-word RX concatenator and the NIC RX FIFO. It watches the 64-bit word stream and makes one decision per frame at its first word: forward the whole frame if the FIFO can hold a maximum-size frame, otherwise discard it entirely. It truncates frames that overrun the maximum length and keeps saturating per-frame statistics, so the RX FIFO never receives a partial frame without an error marker.

## Interface
- DATA_W, 64, word width from the concatenator
- KEEP_W, 8, byte-keep width (DATA_W/8)
- MAX_FRAME_WORDS, 190, maximum admitted frame length in words (1518 B)
- FREE_W, 16, width of the FIFO free-space input
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  admission enable, sampled only at a frame's first word
- in_tdata  in  DATA_W  word from the concatenator
- in_tkeep  in  KEEP_W  byte keep
- in_tvalid  in  1  word valid; no backpressure, and back-to-back words are legal
- in_tlast  in  1  last word of frame
- in_tuser  in  1  bad-frame flag, meaningful with in_tlast
- fifo_free_words  in  FREE_W  current free entries in the RX FIFO
- out_tdata  out  DATA_W  forwarded word
- out_tkeep  out  KEEP_W  forwarded keep
- out_tvalid  out  1  FIFO write strobe
- out_tlast  out  1  last word of forwarded frame
- out_tuser  out  1  error marker on last word
- busy  out  1  high while state is not IDLE
- frame_ok_cnt  out  CNT_W  frames forwarded clean
- frame_drop_cnt  out  CNT_W  frames discarded at admission
- frame_err_cnt  out  CNT_W  frames forwarded with out_tuser=1

## Operation
- States: IDLE, PASS, DROP, TRUNC.
- IDLE, when in_tvalid=1:
  - Admit the frame if enable=1 and fifo_free_words >= MAX_FRAME_WORDS.
  - Admitted: forward the word and set word_cnt=1, then go to PASS. If in_tlast=1 on this word, finish the frame (count it as below) and stay in IDLE.
  - Not admitted: go to DROP. If in_tlast=1, increment frame_drop_cnt and stay in IDLE.
- PASS, per valid word: forward the word and increment word_cnt.
  - in_tlast=1: out_tuser=in_tuser. Increment frame_err_cnt if in_tuser=1, else frame_ok_cnt. Go to IDLE.
  - in_tlast=0 and this word is number MAX_FRAME_WORDS: force out_tlast=1 and out_tuser=1, increment frame_err_cnt, go to TRUNC.
- DROP, per valid word: discard it. On in_tlast, increment frame_drop_cnt and go to IDLE.
- TRUNC, per valid word: discard it with no count. On in_tlast, go to IDLE.
- enable changing mid-frame has no effect on the frame in progress.
- Counters saturate at all-ones and never wrap.
- word_cnt is wide enough to count to MAX_FRAME_WORDS and never wraps.

## Timing
- All outputs are registered. A forwarded word appears on out_* exactly 1 cycle after it is sampled on in_*.
- out_tvalid is a single-cycle pulse per word.
- Counters update in the cycle after the deciding word.
- When out_tvalid=0, out_tdata, out_tkeep, out_tlast and out_tuser are 0.
- Reset values: every output 0, counters 0, state IDLE, word_cnt 0.
- Reset mid-frame: the frame in progress is abandoned with no tlast emitted. The next in_tvalid after reset is treated as a new frame's first word.
- fifo_free_words is sampled only in IDLE, in the cycle of the first word.

## Configuration
- RX_FRAME_CTRL_STATS_EN defined: the three saturating counters are implemented as specified.
- Not defined: the counter registers are removed, the counter outputs are constant 0, and forwarding behaviour is identical.

## Structure
- Shared package nic_rx_pkg holds:
  - the state enum (IDLE/PASS/DROP/TRUNC)
  - default DATA_W, KEEP_W and MAX_FRAME_WORDS
  - the counter width
- One sub-module: rx_sat_counter (CNT_W saturating counter with increment input and synchronous reset), instantiated three times under the macro.

## Test plan
- Admitted frame: enable=1, free=200, 3-word frame, tuser=0 -> 3 out_tvalid pulses each 1 cycle late, tlast on word 3, frame_ok_cnt=1.
- Space drop: free=100, 4-word frame -> no out_tvalid, frame_drop_cnt=1, busy high until 1 cycle after tlast.
- Bad frame: 2-word frame with tuser=1 on tlast -> out_tuser=1 on word 2, frame_err_cnt=1, frame_ok_cnt=0.
- Truncation: MAX_FRAME_WORDS=4, 6-word frame -> 4 words out, word 4 has tlast=1 and tuser=1, words 5-6 discarded, frame_err_cnt=1.
- Boundaries:
  - single-word admitted frame -> ok_cnt=1, state stays IDLE.
  - enable dropped mid-PASS -> frame completes.
  - reset mid-PASS -> all outputs 0 next cycle, and a following 2-word frame is admitted normally.
- Saturation: preload frame_drop_cnt to all-ones, then drop one frame -> value unchanged. Without the macro, all counters read 0.
